// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm
// Two-operand calculator entry sequencer. Tracks digit entry per operand (capped at DIGITS),
// latches the operator, starts the ALU, supports chained operations, repeat-equals, clear,
// and an ERROR state reached on ALU error or ALU timeout.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   digitRecived        : digit key strobe (1 cycle)
//   opRecived, opCode   : operator key strobe and its code
//   eqRecived           : equals key strobe
//   clrRecived          : clear key strobe
//   aluDone, aluErr     : ALU result valid pulse; error flag qualified by aluDone
//   salida              : display select (0 op1, 1 op2, 2 result, 3 error)
//   newOperation, chain : result-to-operand1 pulses (op after RESULT / op mid-entry)
//   digitLoad           : shift digit into active operand register
//   operandClr          : clear active operand register
//   digitCount          : digits held in the active operand
//   opLatched           : operator used by the next ALU start
//   aluStart            : ALU start pulse
//   busy                : high while waiting on the ALU
// All outputs are registered.
module calc_entry_fsm #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned OPW     = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           digitRecived,
  input  logic                           opRecived,
  input  logic [OPW-1:0]                 opCode,
  input  logic                           eqRecived,
  input  logic                           clrRecived,
  input  logic                           aluDone,
  input  logic                           aluErr,
  output logic [1:0]                     salida,
  output logic                           newOperation,
  output logic                           chain,
  output logic                           digitLoad,
  output logic                           operandClr,
  output logic [$clog2(DIGITS+1)-1:0]    digitCount,
  output logic [OPW-1:0]                 opLatched,
  output logic                           aluStart,
  output logic                           busy
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] MaxCount   = CW'(DIGITS);
  localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);

  localparam logic [2:0] StNum1   = 3'd0;
  localparam logic [2:0] StNum2   = 3'd1;
  localparam logic [2:0] StCalc   = 3'd2;
  localparam logic [2:0] StResult = 3'd3;
  localparam logic [2:0] StError  = 3'd4;

  localparam logic [1:0] SelOp1 = 2'd0;
  localparam logic [1:0] SelOp2 = 2'd1;
  localparam logic [1:0] SelRes = 2'd2;
  localparam logic [1:0] SelErr = 2'd3;

  logic [2:0]     state_q, state_d;
  logic [1:0]     salida_q, salida_d;
  logic           new_op_q, new_op_d;
  logic           chain_q, chain_d;
  logic           digit_load_q, digit_load_d;
  logic           operand_clr_q, operand_clr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [OPW-1:0] op_latched_q, op_latched_d;
  logic           alu_start_q, alu_start_d;
  logic           busy_q, busy_d;
  logic [OPW-1:0] pending_op_q, pending_op_d;
  logic           pending_q, pending_d;
  logic [TW-1:0]  timer_q, timer_d;

  logic count_nz;
  logic count_room;

  assign count_nz   = (count_q != '0);
  assign count_room = (count_q < MaxCount);

  always_comb begin
    state_d       = state_q;
    salida_d      = salida_q;
    new_op_d      = 1'b0;
    chain_d       = 1'b0;
    digit_load_d  = 1'b0;
    operand_clr_d = 1'b0;
    count_d       = count_q;
    op_latched_d  = op_latched_q;
    alu_start_d   = 1'b0;
    pending_op_d  = pending_op_q;
    pending_d     = pending_q;
    timer_d       = timer_q;

    if (clrRecived) begin
      // Clear wins over everything, including an aluDone arriving this cycle.
      state_d       = StNum1;
      salida_d      = SelOp1;
      count_d       = '0;
      operand_clr_d = 1'b1;
    end else begin
      case (state_q)
        StNum1, StNum2: begin
          // Strobes are decoded by priority; a lower strobe is dropped even when the
          // higher one is ignored in this state.
          if (eqRecived) begin
            if (state_q == StNum2 && count_nz) begin
              alu_start_d = 1'b1;
              pending_d   = 1'b0;
              timer_d     = TW'(1);
              state_d     = StCalc;
            end
          end else if (opRecived) begin
            if (count_nz) begin
              if (state_q == StNum1) begin
                op_latched_d  = opCode;
                count_d       = '0;
                operand_clr_d = 1'b1;
                salida_d      = SelOp2;
                state_d       = StNum2;
              end else begin
                // Op mid-entry: compute now, apply the new operator once the result lands.
                alu_start_d  = 1'b1;
                pending_op_d = opCode;
                pending_d    = 1'b1;
                timer_d      = TW'(1);
                state_d      = StCalc;
              end
            end
          end else if (digitRecived) begin
            if (count_room) begin
              digit_load_d = 1'b1;
              count_d      = count_q + 1'b1;
            end
          end
        end

        StCalc: begin
          if (aluDone) begin
            if (aluErr) begin
              salida_d = SelErr;
              state_d  = StError;
            end else if (pending_q) begin
              chain_d       = 1'b1;
              op_latched_d  = pending_op_q;
              count_d       = '0;
              operand_clr_d = 1'b1;
              salida_d      = SelOp2;
              state_d       = StNum2;
            end else begin
              salida_d = SelRes;
              state_d  = StResult;
            end
          end else if (timer_q == TimeoutVal) begin
            salida_d = SelErr;
            state_d  = StError;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        StResult: begin
          if (eqRecived) begin
            // Repeat-equals reuses operand2 and the latched operator.
            alu_start_d = 1'b1;
            pending_d   = 1'b0;
            timer_d     = TW'(1);
            state_d     = StCalc;
          end else if (opRecived) begin
            new_op_d      = 1'b1;
            op_latched_d  = opCode;
            count_d       = '0;
            operand_clr_d = 1'b1;
            salida_d      = SelOp2;
            state_d       = StNum2;
          end else if (digitRecived) begin
            // Fresh entry: clear and load in the same cycle so the digit lands in an empty register.
            operand_clr_d = 1'b1;
            digit_load_d  = 1'b1;
            count_d       = CW'(1);
            salida_d      = SelOp1;
            state_d       = StNum1;
          end
        end

        StError: begin
          // Only clear leaves ERROR.
        end

        default: begin
          state_d  = StNum1;
          salida_d = SelOp1;
          count_d  = '0;
        end
      endcase
    end

    busy_d = (state_d == StCalc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StNum1;
      salida_q      <= SelOp1;
      new_op_q      <= 1'b0;
      chain_q       <= 1'b0;
      digit_load_q  <= 1'b0;
      operand_clr_q <= 1'b0;
      count_q       <= '0;
      op_latched_q  <= '0;
      alu_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      pending_op_q  <= '0;
      pending_q     <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      salida_q      <= salida_d;
      new_op_q      <= new_op_d;
      chain_q       <= chain_d;
      digit_load_q  <= digit_load_d;
      operand_clr_q <= operand_clr_d;
      count_q       <= count_d;
      op_latched_q  <= op_latched_d;
      alu_start_q   <= alu_start_d;
      busy_q        <= busy_d;
      pending_op_q  <= pending_op_d;
      pending_q     <= pending_d;
      timer_q       <= timer_d;
    end
  end

  assign salida       = salida_q;
  assign newOperation = new_op_q;
  assign chain        = chain_q;
  assign digitLoad    = digit_load_q;
  assign operandClr   = operand_clr_q;
  assign digitCount   = count_q;
  assign opLatched    = op_latched_q;
  assign aluStart     = alu_start_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Scoreboard bench for calc_entry_fsm: a driver applies directed then random key/ALU strobes
// and pushes the reference model's expected outputs; a monitor pops and compares after each edge.
module tb_calc_entry_fsm;

  localparam int DIGITS  = 4;
  localparam int OPW     = 2;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DIGITS + 1);

  // Model modes
  localparam int N1 = 0, N2 = 1, CA = 2, RS = 3, ER = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           digitRecived, opRecived, eqRecived, clrRecived, aluDone, aluErr;
  logic [OPW-1:0] opCode;
  logic [1:0]     salida;
  logic           newOperation, chain, digitLoad, operandClr, aluStart, busy;
  logic [CW-1:0]  digitCount;
  logic [OPW-1:0] opLatched;

  calc_entry_fsm #(.DIGITS(DIGITS), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .digitRecived (digitRecived),
    .opRecived    (opRecived),
    .opCode       (opCode),
    .eqRecived    (eqRecived),
    .clrRecived   (clrRecived),
    .aluDone      (aluDone),
    .aluErr       (aluErr),
    .salida       (salida),
    .newOperation (newOperation),
    .chain        (chain),
    .digitLoad    (digitLoad),
    .operandClr   (operandClr),
    .digitCount   (digitCount),
    .opLatched    (opLatched),
    .aluStart     (aluStart),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sal, newop, chn, dload, oclr, cnt, oplat, start, bsy;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int mode, cnt, oplat, sal, pend, pop, age;

  task automatic model_reset();
    mode = N1; cnt = 0; oplat = 0; sal = 0; pend = 0; pop = 0; age = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    if (act !== 32'(exp)) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input exp_t x);
    vectors++;
    chk("salida", 32'(salida), x.sal);
    chk("newOperation", 32'(newOperation), x.newop);
    chk("chain", 32'(chain), x.chn);
    chk("digitLoad", 32'(digitLoad), x.dload);
    chk("operandClr", 32'(operandClr), x.oclr);
    chk("digitCount", 32'(digitCount), x.cnt);
    chk("opLatched", 32'(opLatched), x.oplat);
    chk("aluStart", 32'(aluStart), x.start);
    chk("busy", 32'(busy), x.bsy);
  endtask

  // One cycle of the key/ALU rules; pushes the outputs expected after the coming edge.
  task automatic model(input bit d, input bit o, input int oc, input bit e, input bit c,
                       input bit dn, input bit er);
    exp_t x;
    int nw = 0, ch = 0, dl = 0, cl = 0, st = 0;
    if (c) begin
      mode = N1; cnt = 0; cl = 1; sal = 0;
    end else begin
      case (mode)
        N1, N2: begin
          if (e) begin
            if (mode == N2 && cnt > 0) begin st = 1; mode = CA; pend = 0; age = 1; end
          end else if (o) begin
            if (cnt > 0) begin
              if (mode == N1) begin
                oplat = oc; cnt = 0; cl = 1; mode = N2; sal = 1;
              end else begin
                st = 1; pop = oc; pend = 1; mode = CA; age = 1;
              end
            end
          end else if (d) begin
            if (cnt < DIGITS) begin dl = 1; cnt++; end
          end
        end
        CA: begin
          if (dn) begin
            if (er) begin mode = ER; sal = 3; end
            else if (pend != 0) begin ch = 1; oplat = pop; cnt = 0; cl = 1; mode = N2; sal = 1; end
            else begin mode = RS; sal = 2; end
          end else if (age == TIMEOUT) begin
            mode = ER; sal = 3;
          end else begin
            age++;
          end
        end
        RS: begin
          if (e) begin st = 1; mode = CA; pend = 0; age = 1; end
          else if (o) begin nw = 1; oplat = oc; cnt = 0; cl = 1; mode = N2; sal = 1; end
          else if (d) begin cl = 1; dl = 1; cnt = 1; mode = N1; sal = 0; end
        end
        default: ;
      endcase
    end
    x.sal = sal; x.newop = nw; x.chn = ch; x.dload = dl; x.oclr = cl; x.cnt = cnt;
    x.oplat = oplat; x.start = st; x.bsy = (mode == CA) ? 1 : 0;
    q.push_back(x);
  endtask

  task automatic step(input bit d, input bit o, input int oc, input bit e, input bit c,
                      input bit dn, input bit er);
    logic [31:0] ocv;
    @(negedge clk);
    ocv = 32'(oc);
    digitRecived = d; opRecived = o; opCode = ocv[OPW-1:0]; eqRecived = e;
    clrRecived = c; aluDone = dn; aluErr = er;
    model(d, o, oc, e, c, dn, er);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic zero_inputs();
    digitRecived = 0; opRecived = 0; opCode = '0; eqRecived = 0;
    clrRecived = 0; aluDone = 0; aluErr = 0;
  endtask

  // Reset asserted between edges; outputs must drop before any clock edge.
  task automatic async_reset();
    exp_t z;
    z = '{default: 0};
    @(negedge clk);
    zero_inputs();
    #1 rst = 1'b0;
    #1 check_all(z);
    model_reset();
    #1 rst = 1'b1;
    model(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check_all(x);
      end
    end
  end

  initial begin
    exp_t z;
    int d_pct;
    z = '{default: 0};
    zero_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all(z);
    @(negedge clk);
    rst = 1'b1;

    // Digit cap: fifth digit dropped
    repeat (5) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    // digit, op(2), digit, eq, aluDone three cycles later
    step(1, 0, 0, 0, 0, 0, 0); step(0, 1, 2, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 1, 0, 0, 0);
    idle(2); step(0, 0, 0, 0, 0, 1, 0);
    // Repeat-equals, op(0) new operation, digit, op(1), digit, op(3) chain
    step(0, 0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0); step(0, 1, 3, 0, 0, 0, 0); idle(1);
    step(0, 0, 0, 0, 0, 1, 0);
    // ALU error, ignored strobes in ERROR, clear out
    step(1, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0); step(0, 1, 2, 0, 0, 0, 0); step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    // Timeout, and aluDone on the timeout cycle
    step(1, 0, 0, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0); idle(TIMEOUT + 1);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0); idle(TIMEOUT - 1); step(0, 0, 0, 0, 0, 1, 0);
    // clr+eq in NUM2; clr beats aluDone
    step(0, 1, 2, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0); step(0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0); step(0, 1, 2, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 1, 1, 0);
    // Async reset mid-CALC
    step(1, 0, 0, 0, 0, 0, 0); step(0, 1, 3, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0); idle(3);
    async_reset();
    step(1, 0, 0, 0, 0, 0, 0);

    // Random phase; some blocks starve aluDone to reach the timeout
    for (int blk = 0; blk < 8; blk++) begin
      d_pct = (blk % 3 == 2) ? 3 : 20;
      for (int i = 0; i < 400; i++) begin
        step(($urandom % 3) == 0, ($urandom % 6) == 0, int'($urandom % 4),
             ($urandom % 7) == 0, ($urandom % 40) == 0,
             ($urandom % 100) < d_pct, ($urandom % 5) == 0);
      end
      if (blk == 4) async_reset();
    end

    idle(1);
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_entry_fsm.md
# calc_entry_fsm

Parametrised calculator entry sequencer: the next generation of the two-operand entry FSM. It tracks operand entry with a per-operand digit limit and issues start pulses to the arithmetic unit. It supports chained operations, repeat-equals, clear, and an error state driven by ALU error or ALU timeout. It sits between the keypad decoder (single-cycle key strobes) and the operand registers, ALU and display mux.

## Interface
Parameters:
- DIGITS, 4, max digits accepted per operand (1..8)
- OPW, 2, operator code width
- TIMEOUT, 16, cycles to wait for aluDone in CALC before entering ERROR (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- digitRecived  in  1  digit key strobe, 1 cycle
- opRecived  in  1  operator key strobe, 1 cycle
- opCode  in  OPW  operator code, valid with opRecived
- eqRecived  in  1  equals key strobe
- clrRecived  in  1  clear key strobe
- aluDone  in  1  ALU result valid, 1 cycle
- aluErr  in  1  ALU error, sampled only with aluDone
- salida  out  2  display select: 0 operand1, 1 operand2, 2 result, 3 error
- newOperation  out  1  pulse: result becomes operand1 (new op after RESULT)
- chain  out  1  pulse: result becomes operand1 (op pressed mid-entry)
- digitLoad  out  1  pulse: shift digit into active operand register
- operandClr  out  1  pulse: clear active operand register
- digitCount  out  $clog2(DIGITS+1)  digits in active operand
- opLatched  out  OPW  operator applied by next ALU start
- aluStart  out  1  pulse: start ALU with operand1, operand2, opLatched
- busy  out  1  high while in CALC

## Operation
- States: NUM1, NUM2, CALC, RESULT, ERROR. All outputs registered.
- Reset (rst low, async): state NUM1, every output 0, internal pendingOp/pending/timer 0.
- Per-cycle strobe priority: clr > eq > op > digit. Lower-priority strobes in the same cycle are dropped.
- clr in any state: go to NUM1, digitCount 0, operandClr pulse, opLatched kept.
- NUM1 (salida 0):
  - digit with digitCount<DIGITS: digitLoad, count+1. At count==DIGITS the digit is dropped.
  - op with count>0: opLatched<=opCode, count 0, operandClr, go to NUM2.
  - op with count==0 is ignored. eq is ignored.
- NUM2 (salida 1):
  - digit handling is the same as NUM1.
  - eq with count>0: aluStart, go to CALC, pending=0.
  - op with count>0: aluStart, pendingOp<=opCode, pending=1, go to CALC.
  - eq/op with count==0 is ignored.
- CALC (salida unchanged, busy 1): the timer counts cycles. Key strobes other than clr are dropped.
  - aluDone & aluErr: go to ERROR.
  - aluDone & !aluErr & pending: chain pulse, opLatched<=pendingOp, count 0, operandClr, go to NUM2.
  - aluDone & !aluErr & !pending: go to RESULT.
  - timer reaches TIMEOUT without aluDone: go to ERROR.
- RESULT (salida 2):
  - op: newOperation, opLatched<=opCode, count 0, operandClr, go to NUM2.
  - eq: repeat-equals. aluStart with unchanged operand2/opLatched, go to CALC, pending=0.
  - digit: operandClr and digitLoad in the same cycle, count 1, go to NUM1 (fresh entry).
- ERROR (salida 3): only clr exits. All other strobes are ignored.

## Timing
- Every response appears on the rising edge after the strobe cycle: 1-cycle latency, each pulse exactly 1 cycle wide.
- salida changes on the same edge as the state change.
- aluStart and the entry into CALC share an edge. The timer starts at 1 on the first CALC cycle.
- aluDone in the first CALC cycle is accepted.
- With TIMEOUT=16 and no aluDone, ERROR is entered on the edge ending the 16th CALC cycle.
- aluDone on the same cycle as the timeout: aluDone wins.
- clr on the same cycle as aluDone: clr wins and the ALU result is discarded.
- Async reset mid-CALC: outputs drop to 0 immediately. The FSM resumes in NUM1 on the first edge after rst rises.

## Test plan
- Reset, then DIGITS=4, five digit strobes -> 4 digitLoad pulses, digitCount=4, 5th dropped, salida 0.
- Digit, op(opCode=2), digit, eq; aluDone 3 cycles later -> opLatched=2, aluStart 1 cycle after eq, busy for 3 cycles, then salida 2.
- Chain: digit, op(1), digit, op(3), aluDone -> aluStart on second op, chain pulse, opLatched=3, salida 1, digitCount 0.
- In RESULT: eq -> aluStart repeat. Then op(0) -> newOperation pulse, salida 1. Then digit in a later RESULT -> salida 0, digitCount 1.
- Error paths: aluDone&aluErr -> salida 3; no aluDone for 16 cycles -> salida 3. In ERROR, op/eq/digit ignored; clr -> salida 0.
- Simultaneous clr+eq in NUM2 -> NUM1 with operandClr and no aluStart. Async rst pulse mid-CALC -> all outputs 0 without waiting for a clock edge.
